// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with valid/ready channels and optional skid buffer.
// Build macro IMM_CSR_ZIMM_EN enables ImmSrc=100 as the CSR zimm (zero-extended Instr[19:15]).
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     Instr,
  input  logic [2:0]      ImmSrc,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [XLEN-1:0] ImmExt,
  output logic            ImmErr,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [31:0]     imm32;
  logic            err_d;
  logic [XLEN-1:0] imm_d;
  logic            in_fire;
  logic            out_v;
  logic [XLEN-1:0] imm_q;
  logic            err_q;
  logic            unused_bits;

  assign unused_bits = ^Instr[6:0];

  always_comb begin
    imm32 = '0;
    err_d = 1'b0;
    case (ImmSrc)
      3'b000: imm32 = {{20{Instr[31]}}, Instr[31:20]};
      3'b001: imm32 = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
      3'b010: imm32 = {{19{Instr[31]}}, Instr[31], Instr[7],
                       Instr[30:25], Instr[11:8], 1'b0};
      3'b011: imm32 = {{11{Instr[31]}}, Instr[31], Instr[19:12],
                       Instr[20], Instr[30:21], 1'b0};
      3'b111: imm32 = {Instr[31:12], 12'b0};
`ifdef IMM_CSR_ZIMM_EN
      3'b100: imm32 = {27'b0, Instr[19:15]};
`endif
      default: err_d = 1'b1;
    endcase
  end

  // Native 32-bit value widened by sign extension of bit 31.
  assign imm_d   = XLEN'($signed(imm32));
  assign in_fire = in_valid && in_ready;

  assign out_valid = out_v;
  assign ImmExt    = imm_q;
  assign ImmErr    = err_q;

  if (SKID != 0) begin : g_skid
    logic            skid_v;
    logic [XLEN-1:0] skid_imm;
    logic            skid_err;

    // Ready comes straight from the skid flag: no path from out_ready.
    assign in_ready = !skid_v;

    always_ff @(posedge clk) begin
      if (rst) begin
        out_v    <= 1'b0;
        imm_q    <= '0;
        err_q    <= 1'b0;
        skid_v   <= 1'b0;
        skid_imm <= '0;
        skid_err <= 1'b0;
      end else if (!out_v || out_ready) begin
        if (skid_v) begin
          out_v  <= 1'b1;
          imm_q  <= skid_imm;
          err_q  <= skid_err;
          skid_v <= 1'b0;
        end else begin
          out_v <= in_fire;
          if (in_fire) begin
            imm_q <= imm_d;
            err_q <= err_d;
          end
        end
      end else if (in_fire) begin
        skid_v   <= 1'b1;
        skid_imm <= imm_d;
        skid_err <= err_d;
      end
    end
  end else begin : g_single
    assign in_ready = !out_v || out_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        out_v <= 1'b0;
        imm_q <= '0;
        err_q <= 1'b0;
      end else if (in_fire) begin
        out_v <= 1'b1;
        imm_q <= imm_d;
        err_q <= err_d;
      end else if (out_ready) begin
        out_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: RV32 skid instance and RV64 single-register instance
// share one stimulus stream; each has its own FIFO reference model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Instr;
  logic [2:0]  ImmSrc;
  logic        in_valid;
  logic        out_ready;

  logic        rdy_a, ov_a, err_a;
  logic [31:0] imm_a;
  logic        rdy_b, ov_b, err_b;
  logic [63:0] imm_b;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] imm;
    logic        err;
  } ent_t;

  ent_t q1[$];
  ent_t q0[$];
  logic [63:0] cur_exp;
  logic        cur_err;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SKID(1)) u32 (
    .clk(clk), .rst(rst), .Instr(Instr), .ImmSrc(ImmSrc),
    .in_valid(in_valid), .in_ready(rdy_a), .ImmExt(imm_a),
    .ImmErr(err_a), .out_valid(ov_a), .out_ready(out_ready)
  );

  imm_gen_pipe #(.XLEN(64), .SKID(0)) u64 (
    .clk(clk), .rst(rst), .Instr(Instr), .ImmSrc(ImmSrc),
    .in_valid(in_valid), .in_ready(rdy_b), .ImmExt(imm_b),
    .ImmErr(err_b), .out_valid(ov_b), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Immediate value computed arithmetically from the field weights.
  function automatic void ref_imm(input logic [31:0] ins,
                                  input logic [2:0] src,
                                  output logic [63:0] v,
                                  output logic e);
    longint x;
    x = 0;
    e = 1'b0;
    case (src)
      3'd0: x = longint'($signed(ins)) >>> 20;
      3'd1: begin
        x = (longint'($signed(ins)) >>> 25) * 32;
        x = x + longint'(ins[11:7]);
      end
      3'd2: begin
        x = ins[31] ? -4096 : 0;
        x = x + longint'(ins[7]) * 2048;
        x = x + longint'(ins[30:25]) * 32;
        x = x + longint'(ins[11:8]) * 2;
      end
      3'd3: begin
        x = ins[31] ? -(64'sd1 << 20) : 0;
        x = x + longint'(ins[19:12]) * 4096;
        x = x + longint'(ins[20]) * 2048;
        x = x + longint'(ins[30:21]) * 2;
      end
      3'd7: x = longint'($signed(ins & 32'hFFFF_F000));
`ifdef IMM_CSR_ZIMM_EN
      3'd4: x = longint'(ins[19:15]);
`endif
      default: e = 1'b1;
    endcase
    v = x;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [2:0] src);
    in_valid = v;
    Instr    = ins;
    ImmSrc   = src;
    ref_imm(ins, src, cur_exp, cur_err);
  endtask

  task automatic tick();
    bit rdy1, rdy0;
    #1;
    rdy1 = q1.size() < 2;
    rdy0 = (q0.size() == 0) || out_ready;
    chk("in_ready32", 64'(rdy_a), 64'(rdy1));
    chk("in_ready64", 64'(rdy_b), 64'(rdy0));
    if (rst) begin
      q1.delete();
      q0.delete();
    end else begin
      if (q1.size() > 0 && out_ready) void'(q1.pop_front());
      if (q0.size() > 0 && out_ready) void'(q0.pop_front());
      if (in_valid && rdy1) q1.push_back('{cur_exp, cur_err});
      if (in_valid && rdy0) q0.push_back('{cur_exp, cur_err});
    end
    @(posedge clk);
    #1;
    chk("out_valid32", 64'(ov_a), 64'(q1.size() > 0));
    chk("out_valid64", 64'(ov_b), 64'(q0.size() > 0));
    if (q1.size() > 0) begin
      chk("imm32", 64'(imm_a), 64'(q1[0].imm[31:0]));
      chk("err32", 64'(err_a), 64'(q1[0].err));
    end
    if (q0.size() > 0) begin
      chk("imm64", imm_b, q0[0].imm);
      chk("err64", 64'(err_b), 64'(q0[0].err));
    end
  endtask

  logic [31:0] d_ins[8];
  logic [2:0]  d_src[8];
  logic [63:0] d_exp[8];
  logic        d_err[8];

  initial begin
    d_ins[0] = 32'hFFF0_0093; d_src[0] = 3'd0;
    d_exp[0] = 64'hFFFF_FFFF_FFFF_FFFF; d_err[0] = 1'b0;
    d_ins[1] = 32'hFE11_2E23; d_src[1] = 3'd1;
    d_exp[1] = 64'hFFFF_FFFF_FFFF_FFFC; d_err[1] = 1'b0;
    d_ins[2] = 32'h0000_0463; d_src[2] = 3'd2;
    d_exp[2] = 64'h0000_0000_0000_0008; d_err[2] = 1'b0;
    d_ins[3] = 32'hFFFF_F06F; d_src[3] = 3'd3;
    d_exp[3] = 64'hFFFF_FFFF_FFFF_FFFE; d_err[3] = 1'b0;
    d_ins[4] = 32'h1234_50B7; d_src[4] = 3'd7;
    d_exp[4] = 64'h0000_0000_1234_5000; d_err[4] = 1'b0;
    d_ins[5] = 32'h8000_0037; d_src[5] = 3'd7;
    d_exp[5] = 64'hFFFF_FFFF_8000_0000; d_err[5] = 1'b0;
    d_ins[6] = 32'hFFF0_0093; d_src[6] = 3'd5;
    d_exp[6] = 64'h0; d_err[6] = 1'b1;
    d_ins[7] = 32'h000F_D073; d_src[7] = 3'd4;
`ifdef IMM_CSR_ZIMM_EN
    d_exp[7] = 64'h1F; d_err[7] = 1'b0;
`else
    d_exp[7] = 64'h0; d_err[7] = 1'b1;
`endif

    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 3'd0);
    tick();
    tick();
    chk("rst_imm32", 64'(imm_a), 64'h0);
    chk("rst_imm64", imm_b, 64'h0);
    chk("rst_err32", 64'(err_a), 64'h0);
    rst = 1'b0;
    tick();

    // Directed vectors with literal expectations, one per cycle.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, d_ins[i], d_src[i]);
      cur_exp = d_exp[i];
      cur_err = d_err[i];
      tick();
    end
    drive(1'b0, 32'h0, 3'd0);
    tick();

    // Backpressure: A, B, C offered while the consumer stalls.
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF0_0093, 3'd0);
    tick();
    drive(1'b1, 32'h1234_50B7, 3'd7);
    tick();
    drive(1'b1, 32'hFFFF_F06F, 3'd3);
    tick();
    tick();
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) drive(1'b0, 32'h0, 3'd0);
      tick();
    end

    // Randomized traffic with random stalls.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom,
            3'($urandom_range(0, 7)));
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end

    // Reset with both entries held; old entries must never reappear.
    drive(1'b0, 32'h0, 3'd0);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0463, 3'd2);
    tick();
    drive(1'b1, 32'hFE11_2E23, 3'd1);
    tick();
    drive(1'b0, 32'h0, 3'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_ov32", 64'(ov_a), 64'h0);
    chk("rst_mid_ov64", 64'(ov_b), 64'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
